// File: rtl/attack_controller.sv
// Attack-phase sequencer for the 5x7 naval game: latches the ship layout, resolves
// shots as hit/miss/rejected, tracks shots and hits, and drives the column bitmaps.
module attack_controller #(
  parameter int MAX_SHOTS   = 10,
  parameter int RESULT_HOLD = 381,
  parameter int BLINK_DIV   = 95
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       attack,
  input  logic [2:0] columns_attack,
  input  logic [2:0] rows_attack,
  input  logic [6:0] map_col1,
  input  logic [6:0] map_col2,
  input  logic [6:0] map_col3,
  input  logic [6:0] map_col4,
  input  logic [6:0] map_col5,
  output logic [6:0] col1_out,
  output logic [6:0] col2_out,
  output logic [6:0] col3_out,
  output logic [6:0] col4_out,
  output logic [6:0] col5_out,
  output logic [3:0] shots_left,
  output logic [5:0] hit_count,
  output logic [1:0] result,
  output logic       game_over,
  output logic       win
);

  // state  | meaning
  // IDLE   | attack mode off, display dark
  // ARMED  | waiting for an attack edge
  // CHECK  | resolve latched coordinate (one cycle)
  // RESULT | show result, blink targeted cell, then re-arm or end game
  // WIN    | every ship cell hit, full layout shown
  // LOSE   | out of shots, unhit ship cells blink
  typedef enum logic [2:0] {IDLE, ARMED, CHECK, RESULT, WIN, LOSE} state_t;

  localparam int HW = $clog2(RESULT_HOLD + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);

  state_t          state;
  logic            attack_q;
  logic            fire;
  logic [4:0][6:0] map_in, ship_map, shot_map, hit_map, cell_mask, disp;
  logic [5:0]      target, map_pop;
  logic [2:0]      tcol, trow;
  logic [HW-1:0]   hold_cnt;
  logic [BW-1:0]   blink_cnt;
  logic            blink_on;
  logic            coord_ok, already_shot, is_ship;

  assign map_in = {map_col5, map_col4, map_col3, map_col2, map_col1};
  assign fire   = attack & ~attack_q;

  always_comb begin
    map_pop = '0;
    for (int i = 0; i < 35; i++) map_pop = map_pop + 6'(map_in[i / 7][i % 7]);
  end

  // One-hot mask of the latched target; all-zero for an invalid coordinate so it never blinks
  assign coord_ok = (tcol != 3'd0) && (tcol <= 3'd5) && (trow != 3'd0);
  always_comb begin
    cell_mask = '0;
    if (coord_ok) cell_mask[tcol - 3'd1][trow - 3'd1] = 1'b1;
  end
  assign already_shot = |(shot_map & cell_mask);
  assign is_ship      = |(ship_map & cell_mask);

  always_comb begin
    disp = '0;
    case (state)
      ARMED, CHECK: disp = hit_map;
      RESULT:       disp = (hit_map & ~cell_mask) | (blink_on ? cell_mask : '0);
      WIN:          disp = ship_map;
      LOSE:         disp = hit_map | (blink_on ? (ship_map & ~hit_map) : '0);
      default:      disp = '0;
    endcase
  end

  assign col1_out = disp[0];
  assign col2_out = disp[1];
  assign col3_out = disp[2];
  assign col4_out = disp[3];
  assign col5_out = disp[4];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      attack_q   <= 1'b0;
      ship_map   <= '0;
      shot_map   <= '0;
      hit_map    <= '0;
      target     <= '0;
      tcol       <= '0;
      trow       <= '0;
      hold_cnt   <= '0;
      blink_cnt  <= '0;
      blink_on   <= 1'b0;
      shots_left <= 4'(MAX_SHOTS);
      hit_count  <= '0;
      result     <= 2'b00;
      game_over  <= 1'b0;
      win        <= 1'b0;
    end else begin
      attack_q <= attack;
      if (state != IDLE && !enable) begin
        state      <= IDLE;
        result     <= 2'b00;
        game_over  <= 1'b0;
        win        <= 1'b0;
        shots_left <= 4'(MAX_SHOTS);
        hit_count  <= '0;
      end else begin
        case (state)
          IDLE: if (enable) begin
            ship_map   <= map_in;
            shot_map   <= '0;
            hit_map    <= '0;
            target     <= map_pop;
            shots_left <= 4'(MAX_SHOTS);
            hit_count  <= '0;
            result     <= 2'b00;
            if (map_pop == 6'd0) begin
              state     <= WIN;
              game_over <= 1'b1;
              win       <= 1'b1;
            end else begin
              state <= ARMED;
            end
          end
          ARMED: if (fire) begin
            tcol  <= columns_attack;
            trow  <= rows_attack;
            state <= CHECK;
          end
          CHECK: begin
            if (!coord_ok || already_shot) begin
              result <= 2'b11;
            end else begin
              shot_map   <= shot_map | cell_mask;
              shots_left <= shots_left - 4'd1;
              if (is_ship) begin
                hit_map   <= hit_map | cell_mask;
                hit_count <= hit_count + 6'd1;
                result    <= 2'b01;
              end else begin
                result <= 2'b10;
              end
            end
            hold_cnt  <= HW'(RESULT_HOLD - 1);
            blink_cnt <= BW'(BLINK_DIV - 1);
            blink_on  <= 1'b1;
            state     <= RESULT;
          end
          RESULT: begin
            if (blink_cnt == '0) begin
              blink_cnt <= BW'(BLINK_DIV - 1);
              blink_on  <= ~blink_on;
            end else begin
              blink_cnt <= blink_cnt - BW'(1);
            end
            if (hold_cnt == '0) begin
              if (hit_count == target) begin
                state     <= WIN;
                game_over <= 1'b1;
                win       <= 1'b1;
              end else if (shots_left == 4'd0) begin
                state     <= LOSE;
                game_over <= 1'b1;
                blink_cnt <= BW'(BLINK_DIV - 1);
                blink_on  <= 1'b1;
              end else begin
                state  <= ARMED;
                result <= 2'b00;
              end
            end else begin
              hold_cnt <= hold_cnt - HW'(1);
            end
          end
          WIN: ;
          LOSE: begin
            if (blink_cnt == '0) begin
              blink_cnt <= BW'(BLINK_DIV - 1);
              blink_on  <= ~blink_on;
            end else begin
              blink_cnt <= blink_cnt - BW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_attack_controller.sv
// Directed bench for attack_controller: default instance plays the main game,
// a MAX_SHOTS=3 instance sharing the inputs covers the LOSE path.
module tb_attack_controller;

  logic       clk = 1'b0;
  logic       reset, enable, attack;
  logic [2:0] columns_attack, rows_attack;
  logic [6:0] map_col1, map_col2, map_col3, map_col4, map_col5;
  logic [6:0] c1, c2, c3, c4, c5;
  logic [3:0] shots_left;
  logic [5:0] hit_count;
  logic [1:0] result;
  logic       game_over, win;
  logic [6:0] d1, d2, d3, d4, d5;
  logic [3:0] o1_shots;
  logic [5:0] o1_hits;
  logic [1:0] o1_result;
  logic       o1_game_over, o1_win;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  attack_controller dut (
    .clk(clk), .reset(reset), .enable(enable), .attack(attack),
    .columns_attack(columns_attack), .rows_attack(rows_attack),
    .map_col1(map_col1), .map_col2(map_col2), .map_col3(map_col3),
    .map_col4(map_col4), .map_col5(map_col5),
    .col1_out(c1), .col2_out(c2), .col3_out(c3), .col4_out(c4), .col5_out(c5),
    .shots_left(shots_left), .hit_count(hit_count), .result(result),
    .game_over(game_over), .win(win)
  );

  attack_controller #(.MAX_SHOTS(3)) dut_lose (
    .clk(clk), .reset(reset), .enable(enable), .attack(attack),
    .columns_attack(columns_attack), .rows_attack(rows_attack),
    .map_col1(map_col1), .map_col2(map_col2), .map_col3(map_col3),
    .map_col4(map_col4), .map_col5(map_col5),
    .col1_out(d1), .col2_out(d2), .col3_out(d3), .col4_out(d4), .col5_out(d5),
    .shots_left(o1_shots), .hit_count(o1_hits), .result(o1_result),
    .game_over(o1_game_over), .win(o1_win)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns at the first RESULT cycle (two edges after the attack edge)
  task automatic fire(input logic [2:0] c, input logic [2:0] r);
    columns_attack = c;
    rows_attack    = r;
    attack = 1'b1;
    tick(1);
    attack = 1'b0;
    tick(1);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; attack = 1'b0;
    columns_attack = 3'd0; rows_attack = 3'd0;
    map_col1 = 7'b0000111; map_col2 = 7'd0; map_col3 = 7'd0;
    map_col4 = 7'd0; map_col5 = 7'd0;
    tick(2);
    chk("rst_shots", shots_left, 10);
    chk("rst_hits", hit_count, 0);
    chk("rst_result", result, 0);
    chk("rst_over", {game_over, win}, 0);
    chk("rst_col1", c1, 0);

    reset = 1'b1; tick(1);
    enable = 1'b1; tick(1);
    chk("armed_shots", shots_left, 10);
    chk("armed_cols", {c1, c2, c3, c4, c5}, 0);

    fire(3'd1, 3'd2);
    chk("hit_result", result, 2'b01);
    chk("hit_count", hit_count, 1);
    chk("hit_shots", shots_left, 9);
    chk("hit_blink_on0", c1, 7'b0000010);
    tick(95);
    chk("hit_blink_off", c1, 7'b0000000);
    chk("hit_result_held", result, 2'b01);
    tick(95);
    chk("hit_blink_on1", c1, 7'b0000010);
    tick(191);
    chk("rearm_result", result, 2'b00);
    chk("rearm_col1", c1, 7'b0000010);
    tick(10);
    chk("steady_col1", c1, 7'b0000010);

    fire(3'd3, 3'd5);
    chk("miss_result", result, 2'b10);
    chk("miss_shots", shots_left, 8);
    chk("miss_col1", c1, 7'b0000010);
    chk("miss_col3_blink", c3, 7'b0010000);
    tick(10);
    attack = 1'b1; tick(1); attack = 1'b0;
    tick(370);
    chk("result_fire_ignored_shots", shots_left, 8);
    chk("result_fire_ignored_res", result, 2'b00);
    chk("miss_col3_unlit", c3, 7'b0000000);

    fire(3'd3, 3'd5);
    chk("repeat_result", result, 2'b11);
    chk("repeat_shots", shots_left, 8);
    tick(381);
    fire(3'd6, 3'd1);
    chk("col6_result", result, 2'b11);
    chk("col6_shots", shots_left, 8);
    chk("col6_noblink", {c1, c2, c3, c4, c5}, {7'b0000010, 28'd0});
    tick(381);
    fire(3'd1, 3'd0);
    chk("row0_result", result, 2'b11);
    chk("row0_shots", shots_left, 8);
    tick(381);

    // attack stays high through RESULT and into ARMED: only one shot
    columns_attack = 3'd1; rows_attack = 3'd1; attack = 1'b1;
    tick(2);
    chk("hit2_result", result, 2'b01);
    chk("hit2_count", hit_count, 2);
    tick(386);
    chk("held_one_shot", shots_left, 7);
    chk("held_result", result, 2'b00);
    attack = 1'b0; tick(1);

    columns_attack = 3'd1; rows_attack = 3'd3; attack = 1'b1;
    tick(2);
    chk("hit3_count", hit_count, 3);
    chk("hit3_shots", shots_left, 6);
    tick(381);
    chk("win_flags", {game_over, win}, 2'b11);
    chk("win_col1", c1, 7'b0000111);
    tick(100);
    chk("win_steady_col1", c1, 7'b0000111);
    chk("win_shots", shots_left, 6);
    attack = 1'b0;

    enable = 1'b0; tick(1);
    chk("idle_flags", {game_over, win}, 0);
    chk("idle_col1", c1, 0);
    enable = 1'b1; tick(1);
    fire(3'd1, 3'd1);
    chk("pre_drop_result", result, 2'b01);
    tick(380);
    enable = 1'b0; tick(1);
    chk("drop_at_expiry_col1", c1, 0);
    chk("drop_at_expiry_result", result, 0);
    chk("drop_at_expiry_over", {game_over, win}, 0);

    enable = 1'b1; tick(1);
    chk("lose_start_shots", o1_shots, 3);
    fire(3'd2, 3'd1); tick(381);
    fire(3'd2, 3'd2); tick(381);
    fire(3'd2, 3'd3);
    chk("lose_last_result", o1_result, 2'b10);
    chk("lose_last_shots", o1_shots, 0);
    tick(381);
    chk("lose_flags", {o1_game_over, o1_win}, 2'b10);
    chk("lose_col1_on", d1, 7'b0000111);
    chk("lose_col2_misses", d2, 0);
    chk("main_after_misses", {game_over, shots_left}, {1'b0, 4'd7});
    tick(95);
    chk("lose_col1_off", d1, 0);
    tick(95);
    chk("lose_col1_on2", d1, 7'b0000111);

    columns_attack = 3'd1; rows_attack = 3'd1; attack = 1'b1;
    tick(1);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_shots", shots_left, 10);
    chk("async_rst_result", result, 0);
    chk("async_rst_cols", {c1, c2, c3, c4, c5}, 0);
    chk("async_rst_lose", {o1_game_over, o1_win, o1_shots}, {2'b00, 4'd3});
    tick(2);
    chk("rst_held_result", result, 0);
    chk("rst_held_hits", hit_count, 0);
    attack = 1'b0; reset = 1'b1;
    tick(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
